mem_port_arbiter: RTL and testbench

//  Shares the single-port byte memory between two requesters:
//   - instruction fetch (PC side, read only);
//   - datapath operand access (TR side, read/write).

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_picker.sv | 33 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DefAddrW = 13;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DP} owner_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection between fetch and datapath requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the datapath always wins ties.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   dp_req_i,
    input  owner_t last_owner_i,
    output owner_t owner_o
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        owner_o = OWN_IF;
        if (if_req_i && dp_req_i) begin
            owner_o = (last_owner_i == OWN_IF) ? OWN_DP : OWN_IF;
        end else if (dp_req_i) begin
            owner_o = OWN_DP;
        end
    end
`else
    owner_t unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        owner_o = OWN_IF;
        if (dp_req_i) begin
            owner_o = OWN_DP;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port byte memory between instruction fetch and datapath access.
// Tie-break policy depends on MEM_ARB_RR_EN (see mem_arb_picker).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CntW-1:0] LatInit = CntW'(MEM_LAT - 1);

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    arb_state_t        state_q, state_d;
    logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    owner_t            pick;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              if_ack_q, if_ack_d;
    logic              dp_ack_q, dp_ack_d;
    logic              busy_q, busy_d;

    mem_arb_picker u_picker (
        .if_req_i     (if_req),
        .dp_req_i     (dp_req),
        .last_owner_i (last_owner_q),
        .owner_o      (pick)
    );

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        if_ack_d     = 1'b0;
        dp_ack_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (if_req || dp_req) begin
                    owner_d = pick;
                    if (pick == OWN_DP) begin
                        addr_d  = dp_addr;
                        we_d    = dp_we;
                        wdata_d = dp_wdata;
                    end else begin
                        // Fetch is read-only regardless of the datapath's write enable.
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    mem_read_d  = ~we_d;
                    mem_write_d = we_d;
                    lat_cnt_d   = LatInit;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (lat_cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    if_ack_d = (owner_q == OWN_IF);
                    dp_ack_d = (owner_q == OWN_DP);
                    state_d  = S_RESP;
                end else begin
                    lat_cnt_d   = lat_cnt_q - CntW'(1);
                    mem_read_d  = ~we_q;
                    mem_write_d = we_q;
                end
            end
            S_RESP: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_DP;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if_ack_q     <= 1'b0;
            dp_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            if_ack_q     <= if_ack_d;
            dp_ack_q     <= dp_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign dp_ack    = dp_ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; tie expectations follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    parameter int unsigned LAT = 3;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [12:0] if_addr = '0;
    logic        if_ack;
    logic        dp_req = 1'b0;
    logic        dp_we = 1'b0;
    logic [12:0] dp_addr = '0;
    logic [7:0]  dp_wdata = '0;
    logic        dp_ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [12:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (13),
        .DATA_W  (8),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .dp_req    (dp_req),
        .dp_we     (dp_we),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .dp_ack    (dp_ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        dp;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    typedef struct {
        logic        ifr;
        logic [12:0] ia;
        logic        dpr;
        logic        we;
        logic [12:0] da;
        logic [7:0]  wd;
        logic [7:0]  mr;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the DUT will sample the request; returns in the ack cycle.
    task automatic expect_access(input logic [7:0] mr, input bit mutate);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'(1), 32'(0));
            return;
        end
        e = sb_q[0];
        tick();
        if (mutate) begin
            dp_addr  = dp_addr + 13'd1;
            if_addr  = if_addr + 13'd1;
            dp_wdata = ~dp_wdata;
        end
        for (int k = 1; k <= int'(LAT); k++) begin
            mem_rdata = (k == int'(LAT)) ? mr : ~mr;
            check("strobe_read", 32'(mem_read), 32'(!e.we));
            check("strobe_write", 32'(mem_write), 32'(e.we));
            check("strobe_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) check("strobe_wdata", 32'(mem_wdata), 32'(e.wdata));
            check("strobe_busy", 32'(busy), 32'(1));
            check("early_ack", 32'({if_ack, dp_ack}), 32'(0));
            tick();
        end
        mem_rdata = ~mr;
        e = sb_q.pop_front();
        check("if_ack", 32'(if_ack), 32'(!e.dp));
        check("dp_ack", 32'(dp_ack), 32'(e.dp));
        check("ack_rdata", 32'(rdata), 32'(e.rdata));
        check("ack_strobes", 32'({mem_read, mem_write}), 32'(0));
        check("ack_busy", 32'(busy), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'(0));
        check({tag, "_acks"}, 32'({if_ack, dp_ack}), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_rdata"}, 32'(rdata), 32'(0));
        check({tag, "_addr"}, 32'(mem_addr), 32'(0));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] model_rdata;
        int         rcyc;
        int         bad;

        vecs[0] = '{1, 13'h0010, 0, 0, 13'h0000, 8'h00, 8'hA5, '{0, 0, 13'h0010, 8'h00, 8'hA5}};
        vecs[1] = '{0, 13'h0000, 1, 1, 13'h1FFF, 8'h3C, 8'h99, '{1, 1, 13'h1FFF, 8'h3C, 8'hA5}};
        vecs[2] = '{0, 13'h0000, 1, 0, 13'h0123, 8'hC3, 8'h5A, '{1, 0, 13'h0123, 8'h00, 8'h5A}};
        vecs[3] = '{1, 13'h0000, 0, 0, 13'h0000, 8'h00, 8'hFF, '{0, 0, 13'h0000, 8'h00, 8'hFF}};
        // Last owner is IF here, so both policies grant DP.
        vecs[4] = '{1, 13'h0AAA, 1, 0, 13'h1555, 8'h00, 8'h42, '{1, 0, 13'h1555, 8'h00, 8'h42}};
        vecs[5] = '{1, 13'h0F0F, 1, 1, 13'h0100, 8'hEE, 8'h11,
                    RR ? exp_t'{0, 0, 13'h0F0F, 8'h00, 8'h11} : exp_t'{1, 1, 13'h0100, 8'hEE, 8'h42}};
        vecs[6] = '{1, 13'h1234, 0, 1, 13'h0777, 8'h55, 8'h6C, '{0, 0, 13'h1234, 8'h00, 8'h6C}};

        // Reset state.
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Three back-to-back accesses with both requests held.
        if_req = 1; if_addr = 13'h0040;
        dp_req = 1; dp_we = 1; dp_addr = 13'h0080; dp_wdata = 8'h77;
        model_rdata = 8'h00;
        for (int g = 0; g < 3; g++) begin
            exp_t e;
            e.dp = RR ? (g == 1) : 1'b1;
            e.we = e.dp;
            e.addr = e.dp ? 13'h0080 : 13'h0040;
            e.wdata = e.dp ? 8'h77 : 8'h00;
            if (!e.dp) model_rdata = 8'h30 + 8'(g);
            e.rdata = model_rdata;
            sb_q.push_back(e);
            expect_access(8'h30 + 8'(g), 1'b0);
            tick();
        end
        if_req = 0;
        dp_req = 0;
        tick();
        check("tie_idle_busy", 32'(busy), 32'(0));

        // Table vectors, one access each.
        for (int i = 0; i < 7; i++) begin
            if_req = vecs[i].ifr; if_addr = vecs[i].ia;
            dp_req = vecs[i].dpr; dp_we = vecs[i].we;
            dp_addr = vecs[i].da; dp_wdata = vecs[i].wd;
            sb_q.push_back(vecs[i].exp);
            expect_access(vecs[i].mr, 1'b0);
            tick();
            if_req = 0;
            dp_req = 0;
        end
        tick();
        check("table_idle_acks", 32'({if_ack, dp_ack, busy}), 32'(0));

        // Address change during BUSY is ignored.
        dp_req = 1; dp_we = 0; dp_addr = 13'h0005;
        sb_q.push_back('{1, 0, 13'h0005, 8'h00, 8'h24});
        expect_access(8'h24, 1'b1);
        tick();
        dp_req = 0;
        tick();

        // Fetch held through its ack counts as a new fetch.
        if_req = 1; if_addr = 13'h0200;
        sb_q.push_back('{0, 0, 13'h0200, 8'h00, 8'h81});
        sb_q.push_back('{0, 0, 13'h0200, 8'h00, 8'h82});
        expect_access(8'h81, 1'b0);
        tick();
        expect_access(8'h82, 1'b0);
        tick();
        if_req = 0;
        tick();
        check("refetch_done", 32'({busy, if_ack}), 32'(0));

        // Reset during the second strobe cycle of a write aborts it silently.
        rcyc = (LAT >= 2) ? 2 : 1;
        dp_req = 1; dp_we = 1; dp_addr = 13'h0300; dp_wdata = 8'h5F;
        tick();
        for (int k = 1; k < rcyc; k++) tick();
        check("abort_in_strobe", 32'(mem_write), 32'(1));
        rst = 1'b0;
        tick();
        check_all_zero("abort");
        rst = 1'b1;
        dp_req = 0;
        bad = 0;
        for (int k = 0; k < int'(2 * LAT + 4); k++) begin
            if (if_ack || dp_ack || mem_read || mem_write || busy) bad++;
            tick();
        end
        check("abort_quiet", 32'(bad), 32'(0));
        if_req = 1; if_addr = 13'h0400;
        sb_q.push_back('{0, 0, 13'h0400, 8'h00, 8'h9E});
        expect_access(8'h9E, 1'b0);
        tick();
        if_req = 0;
        tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
